vcpu_mem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer in front of the single-port vcpu_mem block (16-bit address, 8-bit data, write on clk rising edge, combinational q).
- Requester 0 is the CPU load/store/fetch path.
- Requester 1 is the loader/debug port, which fills program memory and inspects state.
- Converts per-requester req/ack handshakes into correctly timed vcpu_mem we/address/data cycles and returns read data.

---
 rtl/vcpu_mem_arb_pkg.sv | 12 +
 rtl/vcpu_mem_arb_pick.sv | 40 ++++
 rtl/vcpu_mem_arbiter.sv | 100 ++++++++++
 tb/tb_vcpu_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vcpu_mem_arb_pkg.sv
// vcpu_mem_arb_pkg: shared types and constants for the vcpu_mem arbiter
package vcpu_mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } arb_state_t;
  localparam int REQ_CPU = 0;
  localparam int REQ_LOADER = 1;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/vcpu_mem_arb_pick.sv
// vcpu_mem_arb_pick: winner selection for the two-requester memory arbiter
// VCPU_MEM_ARB_PRIO_EN selects fixed m0 priority with a starvation guard instead of round-robin.
module vcpu_mem_arb_pick
  import vcpu_mem_arb_pkg::*;
`ifdef VCPU_MEM_ARB_PRIO_EN
#(
  parameter int MAX_BURST = 4
)
`endif
(
`ifdef VCPU_MEM_ARB_PRIO_EN
  input  logic       clk,
  input  logic       reset,
  input  logic       i_idle,
`endif
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_win
);
`ifdef VCPU_MEM_ARB_PRIO_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  logic [CW-1:0] r_cnt;
  logic w_starve;
  always_comb begin
    w_starve = i_req[REQ_LOADER] && (r_cnt >= MAX_CNT);
    o_win = (i_req[REQ_LOADER] && (!i_req[REQ_CPU] || w_starve)) ? 2'b10 :
            i_req[REQ_CPU] ? 2'b01 : 2'b00;
  end
  // counts back-to-back m0 wins only while m1 is waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_idle)
      r_cnt <= (!i_req[REQ_LOADER] || o_win[REQ_LOADER]) ? '0 : r_cnt + 1'b1;
  end
`else
  always_comb o_win = (&i_req) ? (i_last_grant ? 2'b01 : 2'b10) : i_req;
`endif
endmodule

// File: rtl/vcpu_mem_arbiter.sv
// vcpu_mem_arbiter: two-requester arbiter and IDLE/ACCESS/ACK sequencer for vcpu_mem
// VCPU_MEM_ARB_PRIO_EN switches the policy to m0 priority with a MAX_BURST starvation guard.
module vcpu_mem_arbiter
  import vcpu_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [1:0]            grant
);
  arb_state_t r_state;
  logic [1:0] r_grant, r_ack, w_req, w_win;
  logic r_last_grant, r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data, r_m0_rdata, r_m1_rdata;
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end
  assign w_req = {m1_req, m0_req};
`ifdef VCPU_MEM_ARB_PRIO_EN
  vcpu_mem_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .clk          (clk),
    .reset        (reset),
    .i_idle       (r_state == ST_IDLE),
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_win        (w_win)
  );
`else
  vcpu_mem_arb_pick u_pick (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_win        (w_win)
  );
`endif
  // async reset also kills an in-flight write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= 2'b00;
      r_ack         <= 2'b00;
      r_last_grant  <= 1'b1;
      r_mem_we      <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_m0_rdata    <= '0;
      r_m1_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (|w_req) begin
          r_state       <= ST_ACCESS;
          r_grant       <= w_win;
          r_last_grant  <= w_win[REQ_LOADER];
          r_mem_we      <= w_win[REQ_LOADER] ? m1_we : m0_we;
          r_mem_address <= w_win[REQ_LOADER] ? m1_addr : m0_addr;
          r_mem_data    <= w_win[REQ_LOADER] ? m1_wdata : m0_wdata;
        end
        ST_ACCESS: begin
          r_state  <= ST_ACK;
          r_mem_we <= 1'b0;
          r_ack    <= r_grant;
          r_grant  <= 2'b00;
          if (!r_mem_we && r_grant[REQ_CPU]) r_m0_rdata <= mem_q;
          if (!r_mem_we && r_grant[REQ_LOADER]) r_m1_rdata <= mem_q;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 2'b00;
        end
      endcase
    end
  end
  assign m0_ack      = r_ack[REQ_CPU];
  assign m1_ack      = r_ack[REQ_LOADER];
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;
  assign mem_we      = r_mem_we;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign grant       = r_grant;
endmodule

// File: tb/tb_vcpu_mem_arbiter.sv
// tb_vcpu_mem_arbiter: randomized bench for vcpu_mem_arbiter against a transaction-level model
module tb_vcpu_mem_arbiter;
  localparam int MB = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack, mem_we;
  logic [15:0] m0_addr, m1_addr, mem_address;
  logic [7:0] m0_wdata, m0_rdata, m1_wdata, m1_rdata, mem_data, mem_q;
  logic [1:0] grant;
  logic [7:0] env_mem [65536];
  logic [7:0] ref_mem [65536];

  typedef struct packed { logic we; logic [15:0] addr; logic [7:0] wdata; } op_t;
  op_t q0[$], q1[$];
  op_t cur [2];
  op_t gop;
  bit pend [2];
  logic [7:0] exp_rd [2];
  int acks [2];
  int wins[$];
  int tests = 0, fails = 0;
  int cyc, start_at, free_at, owner, last, burst;
  int p_new = 0, p_drop = 0, p_chg = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_we) env_mem[mem_address] <= mem_data;
  assign mem_q = env_mem[mem_address];

  vcpu_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data(mem_data),
    .mem_q(mem_q), .grant(grant)
  );

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic drive();
    m0_req = pend[0]; m0_we = cur[0].we; m0_addr = cur[0].addr; m0_wdata = cur[0].wdata;
    m1_req = pend[1]; m1_we = cur[1].we; m1_addr = cur[1].addr; m1_wdata = cur[1].wdata;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.we = 1'($urandom_range(1));
    o.addr = ($urandom_range(9) == 0) ? 16'($urandom) : 16'($urandom_range(31));
    o.wdata = 8'($urandom);
    return o;
  endfunction

  // every transaction owns the port for the 3 cycles following its sampling edge
  task automatic model_edge();
    int w;
    cyc++;
    if (cyc >= free_at) begin
      if (!pend[1]) burst = 0;
      if (pend[0] || pend[1]) begin
`ifdef VCPU_MEM_ARB_PRIO_EN
        w = (pend[1] && (!pend[0] || burst >= MB)) ? 1 : 0;
        burst = (w == 1 || !pend[1]) ? 0 : burst + 1;
`else
        w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
`endif
        last = w; owner = w; start_at = cyc; free_at = cyc + 3; gop = cur[w];
        wins.push_back(w);
      end
    end
  endtask

  task automatic model_check();
    bit acc, ak;
    acc = (cyc == start_at);
    ak = (cyc == start_at + 1);
    check("grant", grant, acc ? 2'(1 << owner) : 2'b00);
    check("mem_we", mem_we, acc && gop.we);
    if (acc) begin
      check("mem_address", mem_address, gop.addr);
      if (gop.we) check("mem_data", mem_data, gop.wdata);
    end
    if (ak) begin
      if (gop.we) ref_mem[gop.addr] = gop.wdata;
      else exp_rd[owner] = ref_mem[gop.addr];
      acks[owner]++;
      pend[owner] = 0;
    end
    check("m0_ack", m0_ack, ak && owner == 0);
    check("m1_ack", m1_ack, ak && owner == 1);
    check("m0_rdata", m0_rdata, exp_rd[0]);
    check("m1_rdata", m1_rdata, exp_rd[1]);
  endtask

  task automatic stim();
    for (int r = 0; r < 2; r++) begin
      if (!(cyc == start_at && owner == r)) begin
        if (pend[r]) begin
          if ($urandom_range(99) < p_drop) pend[r] = 0;
          else if ($urandom_range(99) < p_chg) cur[r] = rand_op();
        end else if (r == 0 && q0.size() > 0) begin
          cur[0] = q0.pop_front(); pend[0] = 1;
        end else if (r == 1 && q1.size() > 0) begin
          cur[1] = q1.pop_front(); pend[1] = 1;
        end else if ($urandom_range(99) < p_new) begin
          cur[r] = rand_op(); pend[r] = 1;
        end
      end
    end
    drive();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_check();
      stim();
    end
  endtask

  task automatic drain(string tag);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pend[0] || pend[1]) && k < 6000) begin
      run(1);
      k++;
    end
    check(tag, k < 6000, 1);
  endtask

  task automatic check_reset_vals(string p);
    check({p, "_m0_ack"}, m0_ack, 0);
    check({p, "_m1_ack"}, m1_ack, 0);
    check({p, "_m0_rdata"}, m0_rdata, 0);
    check({p, "_m1_rdata"}, m1_rdata, 0);
    check({p, "_mem_we"}, mem_we, 0);
    check({p, "_mem_address"}, mem_address, 0);
    check({p, "_mem_data"}, mem_data, 0);
    check({p, "_grant"}, grant, 0);
  endtask

  task automatic do_reset(string p);
    reset = 1'b1;
    pend[0] = 0; pend[1] = 0;
    q0.delete(); q1.delete();
    drive();
    #1 check_reset_vals(p);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; free_at = 0; start_at = -10; owner = 0; last = 1; burst = 0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
  endtask

  task automatic wait_access(string tag);
    int k = 0;
    while (cyc != start_at && k < 20) begin
      run(1);
      k++;
    end
    check(tag, cyc == start_at, 1);
  endtask

  initial begin
    int base1;
    for (int a = 0; a < 65536; a++) begin
      env_mem[a] = 8'(a) ^ 8'(a >> 8);
      ref_mem[a] = env_mem[a];
    end
    cur[0] = '0; cur[1] = '0;
    acks[0] = 0; acks[1] = 0;
    do_reset("rst");

    q0.push_back('{1'b1, 16'h0000, 8'h55});
    q0.push_back('{1'b0, 16'h0000, 8'h00});
    drain("wr_rd_drain");
    check("wr_rd_value", m0_rdata, 8'h55);

    base1 = acks[1];
    for (int i = 0; i < 512; i++)
      q1.push_back('{1'b1, 16'(i), (i == 0) ? 8'h55 : (i == 1) ? 8'hFF : 8'h23});
    drain("fill_drain");
    check("fill_m1_acks", acks[1] - base1, 512);
    for (int i = 0; i < 512; i++) q0.push_back('{1'b0, 16'(i), 8'h00});
    drain("readback_drain");
    check("readback_last", m0_rdata, 8'h23);

    do_reset("rst2");
    wins.delete();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    drain("tie_drain");
    for (int i = 0; i < 10; i++)
`ifdef VCPU_MEM_ARB_PRIO_EN
      check($sformatf("tie_order_%0d", i), wins[i], (i % 5 == 4) ? 1 : 0);
`else
      check($sformatf("tie_order_%0d", i), wins[i], i % 2);
`endif

    env_mem[16'h0010] = 8'h23;
    ref_mem[16'h0010] = 8'h23;
    q0.push_back('{1'b1, 16'h0010, 8'hAA});
    wait_access("rst_mid_reach");
    check("rst_mid_we_before", mem_we, 1);
    do_reset("rst_mid");
    q0.push_back('{1'b0, 16'h0010, 8'h00});
    drain("rst_mid_read_drain");
    check("rst_mid_read", m0_rdata, 8'h23);

    base1 = acks[1];
    q0.push_back('{1'b0, 16'h0004, 8'h00});
    wait_access("drop_reach");
    cur[1] = '{1'b1, 16'h0005, 8'h99};
    pend[1] = 1;
    drive();
    p_drop = 100;
    run(1);
    p_drop = 0;
    drain("drop_drain");
    run(3);
    check("drop_no_m1_ack", acks[1] - base1, 0);

    p_new = 30; p_drop = 5; p_chg = 10;
    run(3000);
    p_new = 0; p_drop = 0; p_chg = 0;
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
